bit_serializer: RTL

//   Parallel-to-serial stage feeding the serial input x of seq_detector.

---
 rtl/bit_serializer_if.sv | 33 +++
 rtl/bit_serializer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Groups the parallel-word handshake and the serial output of bit_serializer.
//   slave  : the serializer (takes din/din_valid, drives everything else)
//   master : the word producer / serial consumer side
// Signals
//   din        WIDTH  parallel word
//   din_valid  1      din is valid
//   din_ready  1      serializer can take din this cycle
//   x          1      serial bit
//   x_valid    1      x carries a live bit
//   last       1      x carries the final bit of the current word
//   done       1      one-cycle pulse after a word's final bit
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             last;
  logic             done;

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, last, done
  );

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, last, done
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial stage feeding the serial input x of seq_detector.
//   A WIDTH-bit word is taken over a valid/ready handshake and sent one bit
//   per clk on x. last marks the final bit of a word, done pulses in the cycle
//   after it. Back-to-back words stream with no idle gap.
// Optional feature (macro PARITY_EN): after the data bits a PARITY state sends
//   one even-parity bit (^din); last and done then follow the parity bit.
// Parameters
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1: din[WIDTH-1] first (shift left); 0: din[0] first (shift right)
//   IDLE_BIT   level on x when no bit is valid
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    bit_serializer_if.slave (din, din_valid, din_ready, x, x_valid, last, done)
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifndef PARITY_EN
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
`endif

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
`ifdef PARITY_EN
  logic             par;
`endif
  logic             data_end;
  logic             final_bit;
  logic             accept;
  logic             advance;

  // Bit that leaves the word first for the configured order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Next-state and handshake decode
  always_comb begin
    state_next = state;
    data_end   = (state == SHIFT) && (cnt == CNT_LAST);
`ifdef PARITY_EN
    final_bit  = (state == PARITY);
`else
    final_bit  = (state == SHIFT) && bus.last;
`endif
    // Ready on the final bit lets the next word follow with no bubble.
    bus.din_ready = !reset && ((state == IDLE) || final_bit);
    accept        = bus.din_ready && bus.din_valid;
    advance       = (state == SHIFT) && !data_end;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
`ifdef PARITY_EN
        if (data_end) state_next = PARITY;
`else
        if (final_bit) state_next = accept ? SHIFT : IDLE;
`endif
      end
`ifdef PARITY_EN
      PARITY: state_next = accept ? SHIFT : IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Output register stage: x/x_valid/last/done and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.x       <= IDLE_BIT;
      bus.x_valid <= 1'b0;
      bus.last    <= 1'b0;
      bus.done    <= 1'b0;
      cnt         <= '0;
    end else begin
      bus.done <= final_bit;
      if (accept) begin
        // First bit goes straight from din so it appears at the accept edge.
        bus.x       <= head_bit(bus.din);
        bus.x_valid <= 1'b1;
        bus.last    <= 1'b0;
        cnt         <= '0;
      end else if (advance) begin
        bus.x <= head_bit(shift_word(shreg));
        cnt   <= cnt + CNT_W'(1);
`ifdef PARITY_EN
        bus.last <= 1'b0;
`else
        bus.last <= (cnt == CNT_PENULT);
`endif
`ifdef PARITY_EN
      end else if (data_end) begin
        bus.x    <= par;
        bus.last <= 1'b1;
`endif
      end else if (final_bit) begin
        bus.x       <= IDLE_BIT;
        bus.x_valid <= 1'b0;
        bus.last    <= 1'b0;
      end
    end
  end

  // Data stage: shift register holds the word with the bit on x at the head
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= bus.din;
`ifdef PARITY_EN
      par   <= ^bus.din;
`endif
    end else if (advance) begin
      shreg <= shift_word(shreg);
    end
  end

endmodule
